// File: rtl/ram_burst_reader_pkg.sv
// ram_burst_reader_pkg: shared state encoding, RAM instruction codes and widths for the burst reader.
package ram_burst_reader_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT} state_t;
  localparam logic RAM_READ = 1'b0;
  localparam logic RAM_WRITE = 1'b1;
  localparam int RAM_DATA_W = 16;
  localparam int RAM_ADDR_W = 23;
endpackage

// File: rtl/ram_burst_reader_fifo.sv
// sync_fifo: power-of-two depth output buffer with flush.
// Ports: push/wrData enqueue, pop dequeues head rdData, flush empties it,
// full/empty/count report occupancy. Push and pop together are legal even when full.
module sync_fifo
  import ram_burst_reader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [RAM_DATA_W-1:0]   wrData,
  output logic [RAM_DATA_W-1:0]   rdData,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  logic [RAM_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic doPush, doPop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign doPop = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign rdData = mem[rdPtr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + AW'(doPush);
      rdPtr <= rdPtr + AW'(doPop);
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  always_ff @(posedge clk)
    if (doPush && !flush) mem[wrPtr] <= wrData;
endmodule

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: issues one READ at a time to the async RAM controller and streams words out.
// Ports: start/base_addr/word_count launch a burst, abort cancels it, busy/done report progress;
// w_data/w_valid/w_ready is the output stream; ram_* is the controller request/response interface.
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      word_count,
  output logic                  busy,
  output logic                  done,
  output logic [RAM_DATA_W-1:0] w_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic                  ram_instruction,
  output logic                  ram_latch,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [RAM_DATA_W-1:0] ram_wdata,
  input  logic [RAM_DATA_W-1:0] ram_rdata,
  input  logic                  ram_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, stateNext;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0] remaining;
  logic ramLatch, abortPend, push, pop, flush, full, empty, lastWord, aborting;
  logic [CW-1:0] fifoCount, countNext;
  sync_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
    .wrData(ram_rdata), .rdData(w_data), .full(full), .empty(empty), .count(fifoCount)
  );
  assign w_valid = !empty;
  assign pop = w_valid && w_ready;
  assign busy = state != IDLE;
  assign ram_latch = ramLatch;
  assign ram_addr = addr;
  assign ram_instruction = RAM_READ;
  assign ram_wdata = '0;
  assign aborting = abort || abortPend;
  assign lastWord = remaining == CNT_W'(1);
  // Occupancy after this edge; the latch is predicted one cycle early so it comes from a flop.
  assign countNext = fifoCount + CW'(push) - CW'(pop);
  always_comb begin
    stateNext = state;
    push = 1'b0;
    flush = 1'b0;
    case (state)
      IDLE: stateNext = (start && word_count != '0) ? ISSUE : IDLE;
      // A request already strobed this cycle cannot be withdrawn, so abort is deferred to WAIT.
      ISSUE: begin
        stateNext = ramLatch ? SETTLE : abort ? IDLE : ISSUE;
        flush = !ramLatch && abort;
      end
      SETTLE: stateNext = WAIT;
      WAIT: if (ram_ready) begin
        flush = aborting;
        push = !aborting;
        stateNext = (aborting || lastWord) ? IDLE : ISSUE;
      end
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      remaining <= '0;
      ramLatch <= 1'b0;
      abortPend <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= stateNext;
      ramLatch <= stateNext == ISSUE && countNext != CW'(FIFO_DEPTH);
      abortPend <= stateNext != IDLE && (abortPend || (abort && state != IDLE));
      done <= (state == IDLE && start && word_count == '0) || (push && lastWord);
      if (state == IDLE && start) begin
        addr <= base_addr;
        remaining <= word_count;
      end else if (push) begin
        addr <= addr + ADDR_W'(1);
        remaining <= remaining - CNT_W'(1);
      end
    end
endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Upstream sequencer for the asynchronous RAM controller.
- Accepts a burst command (base word address, word count) and issues one READ transaction at a time on the controller's instruction/latch/ready interface.
- Buffers the returned words in a small FIFO and streams them to the network's weight-load logic over a valid/ready handshake, with backpressure.
- Address increments by one word per read.

Parameters:
- FIFO_DEPTH, 4, output buffer entries; power of two, at least 2.
- ADDR_W, 23, word-address width; maps to the controller's address bits [23:1].
- CNT_W, 16, width of the burst word count.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- abort  in  1  level; cancels the current burst.
- base_addr  in  ADDR_W  first word address.
- word_count  in  CNT_W  number of words to read.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse after the last word has been pushed into the FIFO.
- w_data  out  16  head-of-FIFO word.
- w_valid  out  1  FIFO not empty.
- w_ready  in  1  consumer accepts; a word transfers when w_valid and w_ready are both high.
- ram_instruction  out  1  0 = READ; held at 0.
- ram_latch  out  1  registered one-cycle request strobe to the controller.
- ram_addr  out  ADDR_W  request address; held stable from ISSUE until the transaction completes.
- ram_wdata  out  16  tied to 0.
- ram_rdata  in  16  controller read data; valid when ram_ready is high after a request.
- ram_ready  in  1  controller ready; goes low the cycle after latch is seen and returns high with the data.

Behaviour:
- Reset values: busy=0, done=0, w_valid=0, ram_latch=0, ram_instruction=0, ram_addr=0, FIFO empty, state IDLE, remaining=0.
- IDLE:
  - start=1 with word_count>0: load addr=base_addr and remaining=word_count, go to ISSUE.
  - start=1 with word_count=0: pulse done on the next cycle, no RAM access, stay in IDLE.
  - start while busy is ignored.
- ISSUE:
  - If FIFO occupancy < FIFO_DEPTH: drive ram_latch=1 for exactly this cycle, go to SETTLE.
  - Otherwise hold with latch=0.
- SETTLE: one cycle that masks the stale ram_ready=1; go to WAIT.
- WAIT:
  - On ram_ready=1: push ram_rdata into the FIFO, addr<=addr+1 (wraps modulo 2^ADDR_W), remaining<=remaining-1.
  - If remaining was 1: pulse done and go to IDLE.
  - Otherwise go to ISSUE.
- At most one transaction is outstanding. Space is checked at ISSUE and pops only reduce occupancy, so a push never overflows.
- FIFO rules:
  - Simultaneous push and pop is legal at any occupancy: occupancy is unchanged and ordering is preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - w_data is stable while w_valid=1 and w_ready=0.
- Timing: start at cycle T gives latch at T+1, and the first word is visible on w_valid at T+8 (controller takes 6 cycles). Steady throughput is one word per 7 cycles when the consumer keeps up.
- abort:
  - In ISSUE: go to IDLE immediately and flush the FIFO.
  - In SETTLE or WAIT: the controller cannot be cancelled, so wait for ram_ready=1, discard the data, then flush the FIFO and go to IDLE.
  - done is not pulsed on abort.
  - Abort in IDLE has no effect.
- Asynchronous reset mid-burst returns to reset values at once. The controller must be reset alongside this block.

Decomposition:
- Shared package: state encoding (IDLE, ISSUE, SETTLE, WAIT), the READ=0/WRITE=1 instruction constants, and the RAM data and address widths.
- One sub-module: sync_fifo (parameter DEPTH, 16-bit data; ports push, pop, full, empty, count). Instantiated once.

Test Plan:
- Burst base=0x000100, count=3, w_ready=1 -> addresses 0x100, 0x101, 0x102 issued; data in order; done pulses once; first w_valid at T+8; latch pulses 7 cycles apart.
- Count=10 with w_ready=0 and FIFO_DEPTH=4 -> exactly 4 latches then a stall with busy=1; releasing w_ready delivers all 10 words in order; done after the 10th push.
- base=0x7FFFFE, count=3 -> addresses 0x7FFFFE, 0x7FFFFF, 0x000000.
- start with count=0 -> done pulses the next cycle, no latch, busy stays 0.
- abort asserted in WAIT of word 2 of 5 -> no further latch after ram_ready; FIFO empties (w_valid=0); no done; a new start then works normally.
- start pulsed while busy -> ignored; current burst completes unchanged; rst_n low mid-WAIT -> all outputs return to reset values immediately.
